// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the EX-stage ALU control / MDU sequencer.
package alu_ctrl_pkg;

    // ALU operation codes (4-bit core, zero-extended to CTRL_W at the top)
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SRL  = 4'h2;
    localparam logic [3:0] ALU_DIV  = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_OR   = 4'h5;
    localparam logic [3:0] ALU_XOR  = 4'h6;
    localparam logic [3:0] ALU_SLL  = 4'h9;
    localparam logic [3:0] ALU_SRLV = 4'hA;
    localparam logic [3:0] ALU_SRAV = 4'hB;

    // R-type func field codes
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alu_ctrl_mdu_seq.sv
// mdu_seq: multiply/divide occupancy FSM. A start in IDLE loads the latency
// counter (LAT-1), BUSY counts down to zero, DONE raises the one-cycle HI/LO
// write. Flush in BUSY/DONE returns to IDLE and drops the pending write.
module mdu_seq
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_i,
    input  logic       is_div_i,
    input  logic       flush_i,
    output logic [1:0] state_o,
    output logic       hilo_wr_o,
    output logic       hilo_busy_o
);

    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and latency counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MDU_IDLE: begin
                if (start_i) begin
                    cnt_d   = is_div_i ? DIV_LD : MUL_LD;
                    state_d = MDU_BUSY;
                end
            end
            MDU_BUSY: begin
                if (flush_i) begin
                    state_d = MDU_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = MDU_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs derive from the registered state so async reset clears them at once
    assign state_o     = state_q;
    assign hilo_wr_o   = (state_q == MDU_DONE) && !flush_i;
    assign hilo_busy_o = (state_q != MDU_IDLE);

endmodule

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu: EX-stage ALU control decode plus MDU sequencer interlock.
// Optional macro HILO_FWD_EN: when defined, mfhi/mflo are not stalled in the
// DONE cycle because the datapath forwards the fresh HI/LO value.
module alu_ctrl_mdu
    import alu_ctrl_pkg::*;
#(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              valid,
    input  logic              flush,
    input  logic              Regdst,
    input  logic [1:0]        aluop,
    input  logic [5:0]        func,
    output logic [CTRL_W-1:0] alu_control_signal,
    output logic              shamt,
    output logic              jr,
    output logic              mdu_start,
    output logic [1:0]        mdu_op,
    output logic              hilo_wr,
    output logic              hilo_busy,
    output logic              ismfhi,
    output logic              ismflo,
    output logic              stall
);

    localparam int CNT_W = $clog2(max2(MUL_LAT, DIV_LAT)) + 1;

    logic [3:0] code;
    logic       rtype;
    logic       is_md;
    logic       seq_idle;
    logic       seq_busy;
    logic       seq_done;
    logic [1:0] seq_state;

    // ALU operation decode, forced to add when the slot is empty
    always_comb begin
        code = ALU_ADD;
        if (valid) begin
            case (aluop)
                2'b00: code = ALU_ADD;
                2'b01: code = ALU_SUB;
                2'b11: code = ALU_SUB;
                default: begin
                    case (func)
                        FN_ADD:  code = ALU_ADD;
                        FN_SUB:  code = ALU_SUB;
                        FN_AND:  code = ALU_AND;
                        FN_OR:   code = ALU_OR;
                        FN_XOR:  code = ALU_XOR;
                        FN_SLL:  code = ALU_SLL;
                        FN_SRL:  code = ALU_SRL;
                        FN_SLLV: code = ALU_SLL;
                        FN_SRLV: code = ALU_SRLV;
                        FN_SRAV: code = ALU_SRAV;
                        FN_DIV:  code = ALU_DIV;
                        default: code = ALU_ADD;
                    endcase
                end
            endcase
        end
    end

    assign alu_control_signal = CTRL_W'(code);

    // R-type flags
    assign rtype  = valid && Regdst;
    assign shamt  = rtype && (func == FN_SLL || func == FN_SRL || func == FN_SRA);
    assign jr     = rtype && (func == FN_JR);
    assign ismfhi = rtype && (func == FN_MFHI);
    assign ismflo = rtype && (func == FN_MFLO);
    assign is_md  = rtype && (func[5:2] == FN_MULT[5:2]);
    assign mdu_op = is_md ? func[1:0] : 2'b00;

    assign seq_idle = (seq_state == MDU_IDLE);
    assign seq_busy = (seq_state == MDU_BUSY);
    assign seq_done = (seq_state == MDU_DONE);

`ifdef HILO_FWD_EN
    // DONE forwards HI/LO, so only a new mult/div must wait for IDLE there
    assign stall = (seq_busy && (is_md || ismfhi || ismflo)) || (seq_done && is_md);
`else
    assign stall = (is_md || ismfhi || ismflo) && !seq_idle;
`endif

    // Issue only from IDLE, so a start can never coincide with a stall
    assign mdu_start = is_md && !flush && seq_idle;

    mdu_seq #(
        .MUL_LAT(MUL_LAT),
        .DIV_LAT(DIV_LAT),
        .CNT_W  (CNT_W)
    ) u_seq (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_i    (mdu_start),
        .is_div_i   (func[1]),
        .flush_i    (flush),
        .state_o    (seq_state),
        .hilo_wr_o  (hilo_wr),
        .hilo_busy_o(hilo_busy)
    );

endmodule

// File: tb/tb_alu_ctrl_mdu.sv
// Scoreboard bench for alu_ctrl_mdu: stimulus queues per-cycle expectations and
// predicted start / HI/LO write events; a negedge monitor pops and compares.
module tb_alu_ctrl_mdu;

    localparam int S_ALU = 0, S_SH = 1, S_JR = 2, S_STALL = 3, S_BUSY = 4;
    localparam int S_WR = 5, S_MFHI = 6, S_MFLO = 7, S_START = 8, S_OP = 9;
`ifdef HILO_FWD_EN
    localparam int MFHI_STALL_END = 32;
`else
    localparam int MFHI_STALL_END = 33;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       valid, flush, Regdst;
    logic [1:0] aluop;
    logic [5:0] func;
    logic [3:0] alu_control_signal;
    logic       shamt, jr, mdu_start, hilo_wr, hilo_busy, ismfhi, ismflo, stall;
    logic [1:0] mdu_op;

    alu_ctrl_mdu #(.CTRL_W(4), .MUL_LAT(4), .DIV_LAT(32)) dut (
        .clock(clock), .reset_n(reset_n), .valid(valid), .flush(flush),
        .Regdst(Regdst), .aluop(aluop), .func(func),
        .alu_control_signal(alu_control_signal), .shamt(shamt), .jr(jr),
        .mdu_start(mdu_start), .mdu_op(mdu_op), .hilo_wr(hilo_wr),
        .hilo_busy(hilo_busy), .ismfhi(ismfhi), .ismflo(ismflo), .stall(stall)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int cyc; int sel; logic [31:0] val; } exp_t;
    typedef struct { int cyc; logic [1:0] op; } ev_t;
    typedef struct { logic rd; logic [1:0] op; logic [5:0] fn; logic [3:0] alu; logic sh; logic j; } vec_t;

    exp_t exq[$];
    ev_t  stq[$];
    int   hwq[$];
    int   total = 0;
    int   bad = 0;
    string names [10] = '{"alu", "shamt", "jr", "stall", "hilo_busy", "hilo_wr",
                          "ismfhi", "ismflo", "mdu_start", "mdu_op"};

    vec_t vt [16] = '{
        '{1'b1, 2'b10, 6'h22, 4'h1, 1'b0, 1'b0},
        '{1'b1, 2'b10, 6'h00, 4'h9, 1'b1, 1'b0},
        '{1'b1, 2'b10, 6'h02, 4'h2, 1'b1, 1'b0},
        '{1'b1, 2'b10, 6'h03, 4'h0, 1'b1, 1'b0},
        '{1'b1, 2'b10, 6'h04, 4'h9, 1'b0, 1'b0},
        '{1'b1, 2'b10, 6'h06, 4'hA, 1'b0, 1'b0},
        '{1'b1, 2'b10, 6'h07, 4'hB, 1'b0, 1'b0},
        '{1'b0, 2'b10, 6'h1A, 4'h3, 1'b0, 1'b0},
        '{1'b1, 2'b10, 6'h24, 4'h4, 1'b0, 1'b0},
        '{1'b1, 2'b10, 6'h25, 4'h5, 1'b0, 1'b0},
        '{1'b1, 2'b10, 6'h26, 4'h6, 1'b0, 1'b0},
        '{1'b1, 2'b10, 6'h20, 4'h0, 1'b0, 1'b0},
        '{1'b1, 2'b10, 6'h2A, 4'h0, 1'b0, 1'b0},
        '{1'b1, 2'b10, 6'h08, 4'h0, 1'b0, 1'b1},
        '{1'b1, 2'b01, 6'h00, 4'h1, 1'b1, 1'b0},
        '{1'b1, 2'b11, 6'h08, 4'h1, 1'b0, 1'b1}
    };

    function automatic logic [31:0] act(input int sel);
        case (sel)
            S_ALU:   return 32'(alu_control_signal);
            S_SH:    return 32'(shamt);
            S_JR:    return 32'(jr);
            S_STALL: return 32'(stall);
            S_BUSY:  return 32'(hilo_busy);
            S_WR:    return 32'(hilo_wr);
            S_MFHI:  return 32'(ismfhi);
            S_MFLO:  return 32'(ismflo);
            S_START: return 32'(mdu_start);
            default: return 32'(mdu_op);
        endcase
    endfunction

    task automatic ex(input int sel, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.val = v;
        exq.push_back(e);
    endtask

    task automatic ev_start(input int c, input logic [1:0] op);
        ev_t s;
        s.cyc = c; s.op = op;
        stq.push_back(s);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input logic v, input logic rd, input logic [1:0] op,
                       input logic [5:0] fn, input logic fl);
        valid = v; Regdst = rd; aluop = op; func = fn; flush = fl;
    endtask

    // Monitor: per-cycle expectations plus start / HI/LO write event scoreboards
    always @(negedge clock) begin
        exp_t e;
        ev_t  s;
        int   h;
        while (exq.size() > 0 && exq[0].cyc <= cyc) begin
            e = exq.pop_front();
            total++;
            if (e.cyc != cyc || act(e.sel) !== e.val) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%0h want=%0h (queued for cyc %0d)",
                         names[e.sel], cyc, act(e.sel), e.val, e.cyc);
            end
        end
        if (mdu_start === 1'b1) begin
            total++;
            if (stq.size() == 0) begin
                bad++;
                $display("FAIL start_event cyc=%0d got=unexpected start want=none", cyc);
            end else begin
                s = stq.pop_front();
                if (s.cyc != cyc || mdu_op !== s.op) begin
                    bad++;
                    $display("FAIL start_event got cyc=%0d op=%0d want cyc=%0d op=%0d",
                             cyc, mdu_op, s.cyc, s.op);
                end
            end
        end
        if (hilo_wr === 1'b1) begin
            total++;
            if (hwq.size() == 0) begin
                bad++;
                $display("FAIL hilo_wr_event cyc=%0d got=unexpected write want=none", cyc);
            end else begin
                h = hwq.pop_front();
                if (h != cyc) begin
                    bad++;
                    $display("FAIL hilo_wr_event got cyc=%0d want cyc=%0d", cyc, h);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        drv(0, 0, 2'b00, 6'h00, 0);
        reset_n = 1'b0;

        // reset state
        tick(); tick();
        ex(S_BUSY, 0); ex(S_WR, 0); ex(S_STALL, 0); ex(S_ALU, 0); ex(S_START, 0);
        tick();
        reset_n = 1'b1;

        // decode table
        foreach (vt[i]) begin
            tick();
            drv(1, vt[i].rd, vt[i].op, vt[i].fn, 0);
            ex(S_ALU, 32'(vt[i].alu)); ex(S_SH, 32'(vt[i].sh)); ex(S_JR, 32'(vt[i].j));
            ex(S_STALL, 0); ex(S_START, 0);
        end
        tick(); drv(0, 1, 2'b10, 6'h22, 0); ex(S_ALU, 0);

        // mult: start c0, busy c1..c5, write c5, idle c6
        tick(); drv(1, 1, 2'b10, 6'h18, 0);
        c0 = cyc; ex(S_START, 1); ex(S_OP, 0); ex(S_BUSY, 0);
        ev_start(c0, 2'b00); hwq.push_back(c0 + 5);
        for (int k = 1; k <= 6; k++) begin
            tick(); drv(0, 0, 2'b00, 6'h00, 0);
            ex(S_BUSY, 32'(k <= 5)); ex(S_WR, 32'(k == 5));
        end

        // div then mfhi held: stalls until IDLE (or DONE with forwarding)
        tick(); drv(1, 1, 2'b10, 6'h1A, 0);
        c0 = cyc; ex(S_START, 1); ex(S_OP, 2);
        ev_start(c0, 2'b10); hwq.push_back(c0 + 33);
        for (int k = 1; k <= 34; k++) begin
            tick(); drv(1, 1, 2'b10, 6'h10, 0);
            ex(S_MFHI, 1); ex(S_STALL, 32'(k <= MFHI_STALL_END)); ex(S_BUSY, 32'(k <= 33));
        end
        tick(); drv(0, 0, 2'b00, 6'h00, 0);

        // div then back-to-back mult: held until IDLE, issues once
        tick(); drv(1, 1, 2'b10, 6'h1B, 0);
        c0 = cyc; ex(S_START, 1); ex(S_OP, 3);
        ev_start(c0, 2'b11); hwq.push_back(c0 + 33);
        for (int k = 1; k <= 34; k++) begin
            tick(); drv(1, 1, 2'b10, 6'h18, 0);
            ex(S_STALL, 32'(k <= 33)); ex(S_START, 32'(k == 34));
        end
        ev_start(c0 + 34, 2'b00); hwq.push_back(c0 + 39);
        for (int k = 35; k <= 40; k++) begin
            tick(); drv(0, 0, 2'b00, 6'h00, 0);
            ex(S_BUSY, 32'(k <= 39));
        end

        // flush mid-div: idle next cycle, no HI/LO write ever
        tick(); drv(1, 1, 2'b10, 6'h1A, 0);
        c0 = cyc; ex(S_START, 1);
        ev_start(c0, 2'b10);
        for (int k = 1; k <= 36; k++) begin
            tick(); drv(0, 0, 2'b00, 6'h00, k == 10);
            ex(S_BUSY, 32'(k <= 10)); ex(S_WR, 0);
        end
        // flush in IDLE suppresses issue
        tick(); drv(1, 1, 2'b10, 6'h18, 1); ex(S_START, 0); ex(S_STALL, 0);
        tick(); drv(0, 0, 2'b00, 6'h00, 0); ex(S_BUSY, 0);
        // next mult issues normally
        tick(); drv(1, 1, 2'b10, 6'h19, 0);
        c0 = cyc; ex(S_START, 1); ex(S_OP, 1);
        ev_start(c0, 2'b01); hwq.push_back(c0 + 5);
        for (int k = 1; k <= 6; k++) begin
            tick(); drv(0, 0, 2'b00, 6'h00, 0);
            ex(S_BUSY, 32'(k <= 5)); ex(S_WR, 32'(k == 5));
        end

        // async reset mid-BUSY
        tick(); drv(1, 1, 2'b10, 6'h1A, 0);
        c0 = cyc; ex(S_START, 1);
        ev_start(c0, 2'b10);
        for (int k = 1; k <= 5; k++) begin
            tick(); drv(1, 1, 2'b10, 6'h10, 0);
            ex(S_STALL, 1); ex(S_BUSY, 1);
        end
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        ex(S_BUSY, 0); ex(S_STALL, 0); ex(S_WR, 0);
        tick();
        reset_n = 1'b1;
        ex(S_STALL, 0); ex(S_MFHI, 1); ex(S_BUSY, 0);
        tick(); drv(0, 0, 2'b00, 6'h00, 0);
        tick(); tick();
        #5;

        // every predicted event must have been consumed
        total++;
        if (stq.size() != 0) begin
            bad++;
            $display("FAIL start_missing got=%0d pending want=0", stq.size());
        end
        total++;
        if (hwq.size() != 0) begin
            bad++;
            $display("FAIL hilo_wr_missing got=%0d pending want=0", hwq.size());
        end
        total++;
        if (exq.size() != 0) begin
            bad++;
            $display("FAIL expect_leftover got=%0d pending want=0", exq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_mdu.md
Name: alu_ctrl_mdu

Overview:
Next-generation ALU control unit for the MIPS pipeline EX stage, parametrised in control-code width and multiply/divide latency.
- Decodes aluop/func into the ALU control code, shamt select and jr flag.
- Adds a sequential multiply/divide (MDU) sequencer that issues start pulses, counts the operation latency, writes HI/LO and interlocks mfhi/mflo and back-to-back mult/div with a pipeline stall.

Parameters:
CTRL_W, 4, width of alu_control_signal (min 4; upper bits zero-filled)
MUL_LAT, 4, cycles mult/multu occupy the MDU (>=1)
DIV_LAT, 32, cycles div/divu occupy the MDU (>=1)
CNT_W, $clog2(max(MUL_LAT,DIV_LAT))+1, latency counter width (derived)

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
valid  in  1  EX-stage instruction valid
flush  in  1  pipeline flush; aborts in-flight MDU op
Regdst  in  1  R-type indicator
aluop  in  2  main-control ALU op class
func  in  6  instruction func field
alu_control_signal  out  CTRL_W  ALU operation code
shamt  out  1  shift uses shamt field
jr  out  1  jump-register
mdu_start  out  1  one-cycle start to MDU datapath
mdu_op  out  2  00 mult, 01 multu, 10 div, 11 divu
hilo_wr  out  1  one-cycle HI/LO write enable
hilo_busy  out  1  MDU op in flight
ismfhi  out  1  mfhi in EX
ismflo  out  1  mflo in EX
stall  out  1  hold IF/ID/EX

Behaviour:
- Decode (combinational, gated by valid):
  - aluop 00 -> 0 (add); 01 -> 1 (sub); 11 -> 1.
  - aluop 10, func[5]=1: 0x20->0, 0x22->1, 0x24->4, 0x25->5, 0x26->6.
  - aluop 10, func[5]=0: 0x00->9, 0x02->2, 0x04->9, 0x06->A, 0x07->B, 0x1A->3.
  - Any other func -> 0.
- Flags (R-type only, Regdst=1):
  - shamt: func in {0x00,0x02,0x03}.
  - jr: func=0x08.
  - ismfhi: func=0x10. ismflo: func=0x12.
  - is_md: func in 0x18..0x1B; mdu_op=func[1:0].
- FSM states: IDLE, BUSY, DONE. All registered outputs reset to 0; state resets to IDLE; counter resets to 0.
- IDLE:
  - valid&is_md&!flush -> mdu_start=1 (combinational, this cycle only).
  - Counter loads (div ? DIV_LAT : MUL_LAT)-1; op kind is latched; next state BUSY.
- BUSY:
  - hilo_busy=1.
  - cnt==0 -> DONE; else cnt-1.
  - The op therefore occupies BUSY exactly LAT cycles.
- DONE: hilo_wr=1 for exactly one cycle; hilo_busy=1; next state IDLE.
- Timing: start at cycle 0 -> hilo_wr at cycle LAT+1 -> IDLE at LAT+2.
- stall = valid & (is_md|ismfhi|ismflo) & (state!=IDLE). mdu_start is never asserted while stall=1.
- A stalled instruction holds its inputs; it issues or is not stalled on the first IDLE cycle.
- flush in BUSY or DONE -> IDLE next cycle. No hilo_wr (DONE+flush suppresses it); counter cleared.
- flush in IDLE suppresses mdu_start.
- Reset mid-operation: immediate IDLE; hilo_wr, hilo_busy and stall go to 0 asynchronously.
- Non-MDU instructions never stall.

Optional Feature:
HILO_FWD_EN
- Defined: in DONE, mfhi/mflo are not stalled (the HI/LO result is forwarded by the datapath); stall applies only when state=BUSY, or when state=DONE with is_md.
- Undefined: stall whenever state!=IDLE, as above.

Decomposition:
- alu_ctrl_pkg:
  - ALU code constants (ALU_ADD=0, ALU_SUB=1, ALU_SRL=2, ALU_DIV=3, ALU_AND=4, ALU_OR=5, ALU_XOR=6, ALU_SLL=9, ALU_SRLV=A, ALU_SRAV=B).
  - func codes (FN_JR, FN_MFHI, FN_MFLO, FN_MULT..FN_DIVU).
  - mdu_state_t enum.
- Sub-module mdu_seq: FSM plus counter. Inputs: start, is_div, flush. Outputs: state, hilo_wr, hilo_busy.
- Decode logic stays in alu_ctrl_mdu top.

Test Plan:
1. Reset, then aluop=10, func=0x22, valid=1 -> alu_control_signal=1, stall=0. func=0x00 -> code 9, shamt=1. func=0x08, Regdst=1 -> jr=1.
2. func=0x18 (mult), MUL_LAT=4, cycle 0 -> mdu_start=1, mdu_op=00 at c0; hilo_busy c1-c5; hilo_wr=1 only at c5; IDLE at c6.
3. div issued at c0, DIV_LAT=32; mfhi presented at c1 -> stall=1 c1-c33, stall=0 at c34. With HILO_FWD_EN, stall drops at c33.
4. div in BUSY, second mult presented -> stall held until IDLE, then mdu_start=1 exactly once.
5. flush at c10 of a div -> IDLE at c11, hilo_wr never pulses, next mult issues normally.
6. reset_n low mid-BUSY (async, between edges) -> hilo_busy=0 and stall=0 immediately; after release, mfhi is not stalled.
